// File: rtl/msfsm_event_to_level.sv
// Event-to-level output stage: request events drive four-phase Ro levels; async acks return as events.
// Latency: request event to Ro 1 cycle, Ao change to Ao event SYNC_STAGES+1 cycles; no backpressure.
module msfsm_event_to_level #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 Ro1_PLUS,
    input  logic                 Ro1_MINUS,
    input  logic                 Ro2_PLUS,
    input  logic                 Ro2_MINUS,
    input  logic                 Ao1,
    input  logic                 Ao2,
    output logic                 Ro1,
    output logic                 Ro2,
    output logic                 Ao1_PLUS,
    output logic                 Ao1_MINUS,
    output logic                 Ao2_PLUS,
    output logic                 Ao2_MINUS,
    output logic                 err1,
    output logic                 err2,
    output logic [CNT_WIDTH-1:0] cnt1,
    output logic [CNT_WIDTH-1:0] cnt2
);

    localparam logic [1:0] LOW  = 2'd0;
    localparam logic [1:0] RISE = 2'd1;
    localparam logic [1:0] HIGH = 2'd2;
    localparam logic [1:0] FALL = 2'd3;

    logic [1:0] w_rp;
    logic [1:0] w_rm;
    logic [1:0] w_ao;

    logic [SYNC_STAGES-1:0] r_sync [2];
    logic [1:0]             r_ad;
    logic [1:0]             r_ap;
    logic [1:0]             r_am;
    logic [1:0]             r_state [2];
    logic [1:0]             r_ro;
    logic [1:0]             r_err;
    logic [CNT_WIDTH-1:0]   r_cnt [2];

    logic [1:0] w_next [2];
    logic [1:0] w_err_ev;
    logic [1:0] w_done;

    assign w_rp = {Ro2_PLUS, Ro1_PLUS};
    assign w_rm = {Ro2_MINUS, Ro1_MINUS};
    assign w_ao = {Ao2, Ao1};

    // Only one event can be legal in any given state, so at most one transition fires;
    // every other event present in the same cycle is a protocol error.
    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            w_next[ch]   = r_state[ch];
            w_err_ev[ch] = 1'b0;
            w_done[ch]   = 1'b0;

            if (w_rp[ch] && w_rm[ch]) begin
                w_err_ev[ch] = 1'b1;
            end else if (w_rp[ch]) begin
                if (r_state[ch] == LOW) w_next[ch] = RISE;
                else                    w_err_ev[ch] = 1'b1;
            end else if (w_rm[ch]) begin
                if (r_state[ch] == HIGH) w_next[ch] = FALL;
                else                     w_err_ev[ch] = 1'b1;
            end

            if (r_ap[ch]) begin
                if (r_state[ch] == RISE) w_next[ch] = HIGH;
                else                     w_err_ev[ch] = 1'b1;
            end
            if (r_am[ch]) begin
                if (r_state[ch] == FALL) begin
                    w_next[ch] = LOW;
                    w_done[ch] = 1'b1;
                end else begin
                    w_err_ev[ch] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int ch = 0; ch < 2; ch++) begin
                r_sync[ch]  <= '0;
                r_state[ch] <= LOW;
                r_cnt[ch]   <= '0;
            end
            r_ad  <= '0;
            r_ap  <= '0;
            r_am  <= '0;
            r_ro  <= '0;
            r_err <= '0;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                r_sync[ch]  <= {r_sync[ch][SYNC_STAGES-2:0], w_ao[ch]};
                r_ad[ch]    <= r_sync[ch][SYNC_STAGES-1];
                r_ap[ch]    <= r_sync[ch][SYNC_STAGES-1] & ~r_ad[ch];
                r_am[ch]    <= ~r_sync[ch][SYNC_STAGES-1] & r_ad[ch];
                r_state[ch] <= w_next[ch];
                r_ro[ch]    <= (w_next[ch] == RISE) || (w_next[ch] == HIGH);
                r_err[ch]   <= r_err[ch] | w_err_ev[ch];
                if (w_done[ch]) r_cnt[ch] <= r_cnt[ch] + CNT_WIDTH'(1);
            end
        end
    end

    assign Ro1       = r_ro[0];
    assign Ro2       = r_ro[1];
    assign Ao1_PLUS  = r_ap[0];
    assign Ao1_MINUS = r_am[0];
    assign Ao2_PLUS  = r_ap[1];
    assign Ao2_MINUS = r_am[1];
    assign err1      = r_err[0];
    assign err2      = r_err[1];
    assign cnt1      = r_cnt[0];
    assign cnt2      = r_cnt[1];

endmodule

// File: tb/tb_msfsm_event_to_level.sv
// Directed bench for msfsm_event_to_level (SYNC_STAGES=2, CNT_WIDTH=2).
module tb_msfsm_event_to_level;

    logic       clk = 1'b0;
    logic       reset;
    logic       Ro1_PLUS, Ro1_MINUS, Ro2_PLUS, Ro2_MINUS;
    logic       Ao1, Ao2;
    logic       Ro1, Ro2;
    logic       Ao1_PLUS, Ao1_MINUS, Ao2_PLUS, Ao2_MINUS;
    logic       err1, err2;
    logic [1:0] cnt1, cnt2;

    int n_checks = 0;
    int n_errors = 0;

    msfsm_event_to_level #(.SYNC_STAGES(2), .CNT_WIDTH(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .Ro1_PLUS  (Ro1_PLUS),
        .Ro1_MINUS (Ro1_MINUS),
        .Ro2_PLUS  (Ro2_PLUS),
        .Ro2_MINUS (Ro2_MINUS),
        .Ao1       (Ao1),
        .Ao2       (Ao2),
        .Ro1       (Ro1),
        .Ro2       (Ro2),
        .Ao1_PLUS  (Ao1_PLUS),
        .Ao1_MINUS (Ao1_MINUS),
        .Ao2_PLUS  (Ao2_PLUS),
        .Ao2_MINUS (Ao2_MINUS),
        .err1      (err1),
        .err2      (err2),
        .cnt1      (cnt1),
        .cnt2      (cnt2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle so outputs are sampled and inputs driven away from the edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_req(input int ch, input logic p, input logic m);
        if (ch == 1) begin
            Ro1_PLUS = p; Ro1_MINUS = m;
        end else begin
            Ro2_PLUS = p; Ro2_MINUS = m;
        end
    endtask

    task automatic set_ack(input int ch, input logic v);
        if (ch == 1) Ao1 = v;
        else         Ao2 = v;
    endtask

    task automatic pulse_req(input int ch, input logic p, input logic m);
        drive_req(ch, p, m);
        tick();
        drive_req(ch, 1'b0, 1'b0);
    endtask

    // Full four-phase cycle; ends in LOW with the count already updated.
    task automatic handshake(input int ch);
        pulse_req(ch, 1'b1, 1'b0);
        set_ack(ch, 1'b1);
        tick(4);
        pulse_req(ch, 1'b0, 1'b1);
        set_ack(ch, 1'b0);
        tick(4);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        Ro1_PLUS = 0; Ro1_MINUS = 0; Ro2_PLUS = 0; Ro2_MINUS = 0;
        Ao1 = 0; Ao2 = 0;
        #1;
        do_reset();
        chk("rst_ro1",  Ro1, 0);
        chk("rst_ro2",  Ro2, 0);
        chk("rst_err1", err1, 0);
        chk("rst_err2", err2, 0);
        chk("rst_cnt1", cnt1, 0);
        chk("rst_cnt2", cnt2, 0);
        chk("rst_ev",   {Ao1_PLUS, Ao1_MINUS, Ao2_PLUS, Ao2_MINUS}, 0);

        // 1: single handshake on channel 1 with latency checks
        tick(3);
        pulse_req(1, 1'b1, 1'b0);
        chk("t1_ro1_up", Ro1, 1);
        tick(3);
        set_ack(1, 1'b1);
        tick(2);
        chk("t1_ap_early", Ao1_PLUS, 0);
        tick();
        chk("t1_ap_pulse", Ao1_PLUS, 1);
        tick();
        chk("t1_ap_gone", Ao1_PLUS, 0);
        chk("t1_ro1_high", Ro1, 1);
        pulse_req(1, 1'b0, 1'b1);
        chk("t1_ro1_down", Ro1, 0);
        set_ack(1, 1'b0);
        tick(3);
        chk("t1_am_pulse", Ao1_MINUS, 1);
        chk("t1_cnt_before", cnt1, 0);
        tick();
        chk("t1_cnt1", cnt1, 1);
        chk("t1_err1", err1, 0);

        // 2: interleaved handshakes, channel 2 acks first
        do_reset();
        pulse_req(1, 1'b1, 1'b0);
        chk("t2_ro1_up", Ro1, 1);
        chk("t2_ro2_lo", Ro2, 0);
        pulse_req(2, 1'b1, 1'b0);
        chk("t2_ro2_up", Ro2, 1);
        set_ack(2, 1'b1);
        tick();
        set_ack(1, 1'b1);
        tick(2);
        chk("t2_ap2", {Ao2_PLUS, Ao1_PLUS}, 2'b10);
        tick();
        chk("t2_ap1", {Ao2_PLUS, Ao1_PLUS}, 2'b01);
        tick();
        pulse_req(2, 1'b0, 1'b1);
        chk("t2_ro2_down", {Ro2, Ro1}, 2'b01);
        pulse_req(1, 1'b0, 1'b1);
        chk("t2_ro1_down", {Ro2, Ro1}, 2'b00);
        set_ack(1, 1'b0);
        set_ack(2, 1'b0);
        tick(5);
        chk("t2_cnt1", cnt1, 1);
        chk("t2_cnt2", cnt2, 1);
        chk("t2_errs", {err2, err1}, 0);

        // 3: Ro2_PLUS in HIGH is an error; later handshakes still complete
        do_reset();
        pulse_req(2, 1'b1, 1'b0);
        set_ack(2, 1'b1);
        tick(4);
        pulse_req(2, 1'b1, 1'b0);
        chk("t3_err2", err2, 1);
        chk("t3_ro2_hold", Ro2, 1);
        pulse_req(2, 1'b0, 1'b1);
        chk("t3_ro2_down", Ro2, 0);
        set_ack(2, 1'b0);
        tick(4);
        chk("t3_cnt2_a", cnt2, 1);
        handshake(2);
        chk("t3_cnt2_b", cnt2, 2);
        chk("t3_err2_sticky", err2, 1);
        chk("t3_err1", err1, 0);

        // 4: simultaneous PLUS and MINUS in LOW
        do_reset();
        pulse_req(1, 1'b1, 1'b1);
        chk("t4_ro1", Ro1, 0);
        chk("t4_err1", err1, 1);
        chk("t4_err2", err2, 0);

        // 5: ack rising edge while LOW
        do_reset();
        set_ack(2, 1'b1);
        tick(3);
        chk("t5_ap2", Ao2_PLUS, 1);
        tick();
        chk("t5_err2", err2, 1);
        chk("t5_ro2", Ro2, 0);
        set_ack(2, 1'b0);
        tick(4);

        // 6: counter wrap with 2-bit counters, then reset in RISE
        do_reset();
        handshake(1);
        chk("t6_cnt_1", cnt1, 1);
        handshake(1);
        chk("t6_cnt_2", cnt1, 2);
        handshake(1);
        chk("t6_cnt_3", cnt1, 3);
        handshake(1);
        chk("t6_cnt_0", cnt1, 0);
        handshake(1);
        chk("t6_cnt_1b", cnt1, 1);
        chk("t6_err1", err1, 0);
        pulse_req(1, 1'b1, 1'b0);
        chk("t6_rise", Ro1, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_rst_ro1", Ro1, 0);
        chk("t6_rst_cnt1", cnt1, 0);
        chk("t6_rst_err1", err1, 0);
        tick(5);
        chk("t6_post_err1", err1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
